ql_key_scanner: RTL and testbench
=================================

Name: ql_key_scanner

Overview:
- IPC-side reader of the QL 8x8 keyboard matrix.
- Periodically scans the 64-bit matrix for newly pressed keys and tags each one with the current SHIFT/CTRL/ALT state.
- Queues the tagged codes in a small FIFO, with auto-repeat for the most recent key.
- Provides a registered KEYROW read port; it sits between the PS/2-to-matrix mapper and the IPC emulation.

Parameters:
- DEPTH, 8, key FIFO entries (power of two, 2..16).
- REP_DELAY, 40, scan ticks before the first auto-repeat.
- REP_RATE, 6, scan ticks between subsequent repeats.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce_scan  in  1  one-clk scan strobe, nominally ~1.3 kHz.
- matrix  in  64  QL matrix; bit = row*8+col; 1 = pressed.
- row_sel  in  3  KEYROW row index.
- row_data  out  8  registered matrix[row_sel*8 +: 8].
- key_rd  in  1  pop strobe for the key FIFO.
- key_valid  out  1  FIFO not empty.
- key_data  out  9  {alt,ctrl,shift,code[5:0]} at the FIFO head.
- key_count  out  5  FIFO occupancy.
- overflow  out  1  sticky; a key was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset (async, immediate): all outputs 0, FIFO empty, prev-state register 0, FSM IDLE, repeat tracker idle.
- Modifier bits are 56 (SHIFT), 57 (CTRL), 58 (ALT). They never generate FIFO entries; they only supply the tag bits.
- row_data: registered with one-clk latency; updates every clk regardless of scan state.

FSM:
- IDLE: on ce_scan, latch snap <= matrix and mods <= {matrix[58],matrix[57],matrix[56]}, set idx = 0, go to SCAN.
- SCAN: one bit per clk, idx 0..63.
  - new = snap[idx] & ~prev[idx] & idx not a modifier bit.
  - If new: push {mods, idx}, set last_key = idx, load the repeat counter with REP_DELAY.
  - prev[idx] <= snap[idx] on every SCAN cycle.
  - At idx = 63 go to REPEAT.
  - A ce_scan that arrives during SCAN or REPEAT is ignored; scans are never restarted.
  - Wrap of the 6-bit idx is never reached because the exit is taken at 63.
- REPEAT (1 clk):
  - If the tracker is active and snap[last_key] = 0, the tracker goes idle.
  - Else if the tracker is active: decrement the counter; on reaching 0, push {mods, last_key} and reload with REP_RATE.
  - Go to IDLE.
- Full scan cost is 66 clks; ce_scan spacing must be at least 66 clks.
- When several new keys appear in one scan, all are pushed in ascending idx order and last_key is the highest.

FIFO:
- Push while full: entry dropped, overflow <= 1.
- Push and pop in the same clk while full: both take effect, count unchanged, no overflow.
- Pop while empty: ignored.
- clr_ovf together with a dropping push: overflow stays 1 (set wins).
- key_data is valid whenever key_valid = 1; head advances the clk after key_rd.
- key_count is exact, range 0..DEPTH.

Decomposition:
- Package ql_kbd_pkg:
  - Modifier bit indices KEY_SHIFT/KEY_CTRL/KEY_ALT = 56/57/58.
  - KEYCODE_W = 6.
  - key_t = {mods[2:0], code[5:0]}.
  - scan_state_t {IDLE, SCAN, REPEAT}.
- Sub-module: ql_key_fifo, a synchronous FIFO with count, full/empty, drop-on-full and overflow flag.

Test Plan:
- Press 'a' (bit 36) with bit 56 held, one ce_scan → after 66 clks key_valid = 1, key_data = 9'h064, key_count = 1; a second scan with the same matrix pushes nothing.
- Bits 36 and 9 asserted together, one scan → two entries popped in order 9'h009 then 9'h024.
- Hold bit 36 (REP_DELAY = 3, REP_RATE = 2) for 10 scans → entries appear after scans 1, 4, 6, 8, 10. Release → no further entries.
- DEPTH = 8: push 9 distinct keys without reading → key_count = 8, overflow = 1. Pulse clr_ovf → overflow = 0. Full with key_rd coincident with a push → count stays 8, overflow stays 0.
- row_sel = 4, matrix row 4 = 8'h11 → row_data = 8'h11 one clk later. Changing row_sel to 7 with bit 56 set gives 8'h01 next clk.
- Assert reset mid-SCAN with entries queued → key_valid, key_count, overflow and row_data go to 0 immediately. After release, the first scan with 'a' still held pushes 'a' again.

Source files
------------

// File: rtl/ql_kbd_pkg.sv
// Shared definitions for the QL keyboard matrix scanner: modifier positions,
// tagged key code layout and scan FSM states.
package ql_kbd_pkg;

  localparam int unsigned KEY_SHIFT = 56;
  localparam int unsigned KEY_CTRL  = 57;
  localparam int unsigned KEY_ALT   = 58;
  localparam int unsigned KEYCODE_W = 6;

  typedef struct packed {
    logic [2:0]           mods;  // {alt, ctrl, shift}
    logic [KEYCODE_W-1:0] code;
  } key_t;

  typedef enum logic [1:0] {IDLE, SCAN, REPEAT} scan_state_t;

  function automatic logic is_modifier(input logic [KEYCODE_W-1:0] idx);
    return (idx == KEYCODE_W'(KEY_SHIFT)) || (idx == KEYCODE_W'(KEY_CTRL)) ||
           (idx == KEYCODE_W'(KEY_ALT));
  endfunction

endpackage

// File: rtl/ql_key_fifo.sv
// Small synchronous key FIFO with exact occupancy count, drop-on-full and a
// sticky overflow flag.
module ql_key_fifo
  import ql_kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  key_t       wdata_i,
  input  logic       pop_i,
  input  logic       clr_ovf_i,
  output logic       empty_o,
  output key_t       rdata_o,
  output logic [4:0] count_o,
  output logic       overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  key_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, do_push, do_pop, drop;

  always_comb begin
    empty_o = (count_q == 5'd0);
    full    = (count_q == 5'(DEPTH));
    do_pop  = pop_i & ~empty_o;
    // A pop in the same clk frees the slot, so a push into a full FIFO still lands.
    do_push = push_i & (~full | do_pop);
    drop    = push_i & full & ~do_pop;

    wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + 5'(do_push) - 5'(do_pop);
    overflow_d = drop ? 1'b1 : (clr_ovf_i ? 1'b0 : overflow_q);

    rdata_o    = empty_o ? key_t'('0) : mem_q[rd_ptr_q];
    count_o    = count_q;
    overflow_o = overflow_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ql_key_scanner.sv
// QL 8x8 keyboard matrix scanner: detects newly pressed keys once per scan
// strobe, tags them with modifier state, auto-repeats the latest key and queues codes.
module ql_key_scanner
  import ql_kbd_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned REP_DELAY = 40,
  parameter int unsigned REP_RATE  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_scan,
  input  logic [63:0] matrix,
  input  logic [2:0]  row_sel,
  output logic [7:0]  row_data,
  input  logic        key_rd,
  output logic        key_valid,
  output logic [8:0]  key_data,
  output logic [4:0]  key_count,
  output logic        overflow,
  input  logic        clr_ovf
);

  localparam int unsigned RepMax = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned CntW   = $clog2(RepMax + 1);

  scan_state_t    state_q, state_d;
  logic [63:0]    snap_q, snap_d;
  logic [63:0]    prev_q, prev_d;
  logic [2:0]     mods_q, mods_d;
  logic [5:0]     idx_q, idx_d;
  logic [5:0]     last_key_q, last_key_d;
  logic [CntW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_act_q, rep_act_d;
  logic           fresh_q, fresh_d;
  logic [7:0]     row_data_q, row_data_d;
  logic           push;
  key_t           push_key;
  key_t           head_key;
  logic           fifo_empty;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    prev_d     = prev_q;
    mods_d     = mods_q;
    idx_d      = idx_q;
    last_key_d = last_key_q;
    rep_cnt_d  = rep_cnt_q;
    rep_act_d  = rep_act_q;
    fresh_d    = fresh_q;
    push       = 1'b0;
    push_key   = '0;
    row_data_d = matrix[{row_sel, 3'b000} +: 8];

    unique case (state_q)
      IDLE: begin
        if (ce_scan) begin
          snap_d  = matrix;
          mods_d  = {matrix[KEY_ALT], matrix[KEY_CTRL], matrix[KEY_SHIFT]};
          idx_d   = 6'd0;
          fresh_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        prev_d[idx_q] = snap_q[idx_q];
        if (snap_q[idx_q] && !prev_q[idx_q] && !is_modifier(idx_q)) begin
          push       = 1'b1;
          push_key   = '{mods: mods_q, code: idx_q};
          last_key_d = idx_q;
          rep_cnt_d  = CntW'(REP_DELAY);
          rep_act_d  = 1'b1;
          fresh_d    = 1'b1;
        end
        if (idx_q == 6'd63) state_d = REPEAT;
        else idx_d = idx_q + 6'd1;
      end
      REPEAT: begin
        // The repeat countdown starts with the scan after the one that saw the press.
        if (rep_act_q && !snap_q[last_key_q]) begin
          rep_act_d = 1'b0;
        end else if (rep_act_q && !fresh_q) begin
          if (rep_cnt_q == CntW'(1)) begin
            push      = 1'b1;
            push_key  = '{mods: mods_q, code: last_key_q};
            rep_cnt_d = CntW'(REP_RATE);
          end else begin
            rep_cnt_d = rep_cnt_q - CntW'(1);
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      prev_q     <= '0;
      mods_q     <= '0;
      idx_q      <= '0;
      last_key_q <= '0;
      rep_cnt_q  <= '0;
      rep_act_q  <= 1'b0;
      fresh_q    <= 1'b0;
      row_data_q <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      prev_q     <= prev_d;
      mods_q     <= mods_d;
      idx_q      <= idx_d;
      last_key_q <= last_key_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_act_q  <= rep_act_d;
      fresh_q    <= fresh_d;
      row_data_q <= row_data_d;
    end
  end

  ql_key_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (push),
    .wdata_i    (push_key),
    .pop_i      (key_rd),
    .clr_ovf_i  (clr_ovf),
    .empty_o    (fifo_empty),
    .rdata_o    (head_key),
    .count_o    (key_count),
    .overflow_o (overflow)
  );

  always_comb begin
    row_data  = row_data_q;
    key_valid = ~fifo_empty;
    key_data  = head_key;
  end

endmodule

// File: tb/tb_ql_key_scanner.sv
// Self-checking bench for ql_key_scanner: directed tables and sequences plus
// randomized scans checked against a scan-level behavioural model.
module tb_ql_key_scanner;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned REP_DELAY = 3;
  localparam int unsigned REP_RATE  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_scan = 1'b0;
  logic [63:0] matrix = '0;
  logic [2:0]  row_sel = '0;
  logic [7:0]  row_data;
  logic        key_rd = 1'b0;
  logic        key_valid;
  logic [8:0]  key_data;
  logic [4:0]  key_count;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  ql_key_scanner #(
    .DEPTH     (DEPTH),
    .REP_DELAY (REP_DELAY),
    .REP_RATE  (REP_RATE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce_scan   (ce_scan),
    .matrix    (matrix),
    .row_sel   (row_sel),
    .row_data  (row_data),
    .key_rd    (key_rd),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_count (key_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // Scan-level reference: set of held keys, queue of codes, repeat deadline in scan numbers.
  logic [63:0] m_prev;
  logic [8:0]  m_q[$];
  bit          m_ovf;
  bit          m_trk;
  int          m_last;
  int          m_scan;
  int          m_next;

  function automatic void m_reset();
    m_prev = '0;
    m_q.delete();
    m_ovf  = 1'b0;
    m_trk  = 1'b0;
    m_last = 0;
    m_scan = 0;
    m_next = 0;
  endfunction

  function automatic void m_push(logic [8:0] k);
    if (m_q.size() < DEPTH) m_q.push_back(k);
    else m_ovf = 1'b1;
  endfunction

  function automatic void model_scan(logic [63:0] m);
    logic [2:0] mods;
    bit any_new;
    mods = {m[58], m[57], m[56]};
    any_new = 1'b0;
    m_scan++;
    for (int i = 0; i < 64; i++) begin
      if (m[i] && !m_prev[i] && !(i inside {56, 57, 58})) begin
        m_push({mods, 6'(i)});
        m_last = i;
        any_new = 1'b1;
      end
    end
    m_prev = m;
    if (any_new) begin
      m_trk  = 1'b1;
      m_next = m_scan + REP_DELAY;
    end else if (m_trk) begin
      if (!m[m_last]) m_trk = 1'b0;
      else if (m_scan == m_next) begin
        m_push({mods, 6'(m_last)});
        m_next = m_next + REP_RATE;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    chk({name, "_count"}, 64'(key_count), 64'(m_q.size()));
    chk({name, "_valid"}, 64'(key_valid), 64'(m_q.size() != 0));
    chk({name, "_ovf"}, 64'(overflow), 64'(m_ovf));
    if (m_q.size() != 0) chk({name, "_head"}, 64'(key_data), 64'(m_q[0]));
  endtask

  task automatic do_scan(input logic [63:0] m);
    matrix = m;
    ce_scan = 1'b1;
    tick();
    ce_scan = 1'b0;
    repeat (66) tick();
    model_scan(m);
  endtask

  // Scan with key_rd/clr_ovf pulsed on the edge that registers the push for index k.
  task automatic scan_pulse(input logic [63:0] m, input int k, input bit rd, input bit clr);
    matrix = m;
    ce_scan = 1'b1;
    tick();
    ce_scan = 1'b0;
    repeat (k) tick();
    key_rd = rd;
    clr_ovf = clr;
    tick();
    key_rd = 1'b0;
    clr_ovf = 1'b0;
    repeat (65 - k) tick();
    if (clr) m_ovf = 1'b0;
    if (rd && m_q.size() != 0) void'(m_q.pop_front());
    model_scan(m);
  endtask

  task automatic pop_chk(input string name);
    chk({name, "_valid"}, 64'(key_valid), 64'(1));
    if (m_q.size() != 0) chk({name, "_data"}, 64'(key_data), 64'(m_q[0]));
    key_rd = 1'b1;
    tick();
    key_rd = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [63:0] m;
    logic [7:0]  exp;
  } row_vec_t;

  row_vec_t    rv[6];
  int          rep_exp[10] = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 5};
  logic [63:0] k9;
  logic [63:0] rm;

  initial begin
    rv[0] = '{3'd4, 64'h0000_0011_0000_0000, 8'h11};
    rv[1] = '{3'd7, 64'h0100_0000_0000_0000, 8'h01};
    rv[2] = '{3'd0, 64'h0000_0000_0000_00A5, 8'hA5};
    rv[3] = '{3'd3, 64'h0000_0000_5A00_0000, 8'h5A};
    rv[4] = '{3'd2, 64'hFFFF_FFFF_FF00_FFFF, 8'h00};
    rv[5] = '{3'd5, 64'h0000_C300_0000_0000, 8'hC3};
    m_reset();

    // Reset holds everything at zero even with a busy matrix.
    matrix = '1;
    row_sel = 3'd4;
    repeat (3) tick();
    chk("rst_valid", 64'(key_valid), 0);
    chk("rst_count", 64'(key_count), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_data", 64'(key_data), 0);
    chk("rst_row", 64'(row_data), 0);
    matrix = '0;
    tick();
    reset = 1'b0;
    tick();

    // Single key with SHIFT, then a rescan of the same matrix.
    do_scan((64'd1 << 36) | (64'd1 << 56));
    chk("a_valid", 64'(key_valid), 1);
    chk("a_data", 64'(key_data), 64'h064);
    chk("a_count", 64'(key_count), 1);
    do_scan((64'd1 << 36) | (64'd1 << 56));
    chk("a_rescan_count", 64'(key_count), 1);
    check_model("a_rescan");
    pop_chk("a_pop");
    do_scan('0);
    check_model("a_release");

    // Two keys in one scan come out in ascending index order.
    do_scan((64'd1 << 36) | (64'd1 << 9));
    chk("two_count", 64'(key_count), 2);
    chk("two_first", 64'(key_data), 64'h009);
    pop_chk("two_pop0");
    chk("two_second", 64'(key_data), 64'h024);
    pop_chk("two_pop1");
    do_scan('0);
    check_model("two_release");

    // Auto-repeat on a held key.
    for (int s = 0; s < 10; s++) begin
      do_scan(64'd1 << 36);
      chk($sformatf("rep_count_s%0d", s + 1), 64'(key_count), 64'(rep_exp[s]));
    end
    check_model("rep_model");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rep_code%0d", i), 64'(key_data), 64'h024);
      pop_chk("rep_pop");
    end
    for (int s = 0; s < 3; s++) do_scan('0);
    chk("rep_release_count", 64'(key_count), 0);

    // Overflow, clear, coincident pop+push on full, set-wins clear.
    k9 = 64'h1FF;
    do_scan(k9);
    chk("ovf_count", 64'(key_count), 8);
    chk("ovf_flag", 64'(overflow), 1);
    chk("ovf_head", 64'(key_data), 64'h000);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    m_ovf = 1'b0;
    chk("ovf_clr", 64'(overflow), 0);
    scan_pulse(k9 | (64'd1 << 20), 20, 1'b1, 1'b0);
    chk("full_rdpush_count", 64'(key_count), 8);
    chk("full_rdpush_ovf", 64'(overflow), 0);
    check_model("full_rdpush");
    scan_pulse(k9 | (64'd3 << 20), 21, 1'b0, 1'b1);
    chk("setwins_ovf", 64'(overflow), 1);
    chk("setwins_count", 64'(key_count), 8);
    check_model("setwins");
    for (int i = 0; i < 8; i++) pop_chk("drain");
    do_scan('0);
    check_model("drain_done");

    // Registered KEYROW port, table driven.
    for (int i = 0; i < 6; i++) begin
      row_sel = rv[i].sel;
      matrix = rv[i].m;
      #1;
      if (i > 0) chk($sformatf("row_hold%0d", i), 64'(row_data), 64'(rv[i-1].exp));
      tick();
      chk($sformatf("row_vec%0d", i), 64'(row_data), 64'(rv[i].exp));
    end
    matrix = '0;
    tick();

    // Reset in the middle of a scan with an entry queued.
    row_sel = 3'd4;
    do_scan(64'd1 << 36);
    chk("mid_pre_count", 64'(key_count), 1);
    chk("mid_pre_row", 64'(row_data), 64'h10);
    ce_scan = 1'b1;
    tick();
    ce_scan = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk("mid_valid", 64'(key_valid), 0);
    chk("mid_count", 64'(key_count), 0);
    chk("mid_ovf", 64'(overflow), 0);
    chk("mid_row", 64'(row_data), 0);
    tick();
    reset = 1'b0;
    m_reset();
    tick();
    do_scan(64'd1 << 36);
    chk("mid_after_count", 64'(key_count), 1);
    chk("mid_after_data", 64'(key_data), 64'h024);
    pop_chk("mid_pop");
    do_scan('0);

    // Randomized scans against the reference model.
    rm = '0;
    for (int s = 0; s < 50; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        rm = '0;
        for (int b = 0; b < int'($urandom_range(0, 4)); b++) rm[$urandom_range(0, 63)] = 1'b1;
      end
      do_scan(rm);
      check_model($sformatf("rnd_s%0d", s));
      for (int p = 0; p < int'($urandom_range(0, 3)); p++) begin
        if (m_q.size() != 0) pop_chk("rnd_pop");
      end
      if ($urandom_range(0, 4) == 0) begin
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        m_ovf = 1'b0;
        chk("rnd_clr", 64'(overflow), 0);
      end
    end
    check_model("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
